// File: rtl/serial_tx.sv
// serial_tx: framed single-wire transmitter (start bit 0, data LSB-first, stop bit 1).
// Accepts one word per valid/ready handshake while idle and drives a registered line.
module serial_tx #(
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter int unsigned DATA_W       = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              tx_out,
   output logic              busy
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]  idx_q,   idx_d;
   logic [CNT_W-1:0]  baud_q,  baud_d;
   logic              tx_out_q, tx_out_d;
   logic              ready_q,  ready_d;
   logic              busy_q,   busy_d;
   logic              bit_end;

   // Next-state, next-line-value and counter updates for the frame sequencer.
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      idx_d    = idx_q;
      baud_d   = baud_q;
      tx_out_d = tx_out_q;
      bit_end  = (baud_q == BAUD_LAST);

      case (state_q)
         S_IDLE: begin
            tx_out_d = 1'b1;
            baud_d   = '0;
            idx_d    = '0;
            // tx_ready is high throughout IDLE, so tx_valid alone completes the handshake
            if (tx_valid) begin
               shift_d  = tx_data;
               state_d  = S_START;
               tx_out_d = 1'b0;
            end
         end
         S_START: begin
            if (bit_end) begin
               baud_d   = '0;
               idx_d    = '0;
               state_d  = S_DATA;
               tx_out_d = shift_q[0];
               shift_d  = shift_q >> 1;
            end else begin
               baud_d = baud_q + CNT_W'(1);
            end
         end
         S_DATA: begin
            if (bit_end) begin
               baud_d = '0;
               if (idx_q == IDX_LAST) begin
                  state_d  = S_STOP;
                  tx_out_d = 1'b1;
               end else begin
                  idx_d    = idx_q + IDX_W'(1);
                  tx_out_d = shift_q[0];
                  shift_d  = shift_q >> 1;
               end
            end else begin
               baud_d = baud_q + CNT_W'(1);
            end
         end
         S_STOP: begin
            if (bit_end) begin
               baud_d   = '0;
               state_d  = S_IDLE;
               tx_out_d = 1'b1;
            end else begin
               baud_d = baud_q + CNT_W'(1);
            end
         end
         default: begin
            state_d  = S_IDLE;
            tx_out_d = 1'b1;
            baud_d   = '0;
            idx_d    = '0;
         end
      endcase

      ready_d = (state_d == S_IDLE);
      busy_d  = ~ready_d;
   end

   // State and output registers; reset abandons any frame and returns the line high.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         shift_q  <= '0;
         idx_q    <= '0;
         baud_q   <= '0;
         tx_out_q <= 1'b1;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         idx_q    <= idx_d;
         baud_q   <= baud_d;
         tx_out_q <= tx_out_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
      end
   end

   assign tx_out   = tx_out_q;
   assign tx_ready = ready_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed checks of serial_tx framing, handshake and reset behaviour.
module tb_serial_tx;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] tx_data, tx_data1;
   logic       tx_valid, tx_valid1;
   logic       tx_ready, tx_out, busy;
   logic       tx_ready1, tx_out1, busy1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   serial_tx #(.CLKS_PER_BIT(4), .DATA_W(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx_out   (tx_out),
      .busy     (busy)
   );

   serial_tx #(.CLKS_PER_BIT(1), .DATA_W(8)) dut1 (
      .clk      (clk),
      .reset    (reset),
      .tx_data  (tx_data1),
      .tx_valid (tx_valid1),
      .tx_ready (tx_ready1),
      .tx_out   (tx_out1),
      .busy     (busy1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // advance one clock; sample point is 1 time unit after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called just after the accepting edge. Checks n cycles of a 4-clk/bit frame of b;
   // optionally rewrites tx_data at cycle chg_at. Full frames also check the return to idle.
   task automatic expect_frame(input logic [7:0] b, input string tag, input int n,
                               input int chg_at, input logic [7:0] chg_data);
      logic [9:0] fr;
      fr = {1'b1, b, 1'b0};
      for (int i = 0; i < n; i++) begin
         if (i == chg_at) tx_data = chg_data;
         check($sformatf("%s_bit_c%0d", tag, i), 32'(tx_out), 32'(fr[i/4]));
         check($sformatf("%s_busy_c%0d", tag, i), 32'(busy), 32'd1);
         if (i == 0) check($sformatf("%s_ready_lo", tag), 32'(tx_ready), 32'd0);
         if (i < n - 1 || n == 40) tick();
      end
      if (n == 40) begin
         check($sformatf("%s_ready_back", tag), 32'(tx_ready), 32'd1);
         check($sformatf("%s_busy_lo", tag), 32'(busy), 32'd0);
         check($sformatf("%s_idle_hi", tag), 32'(tx_out), 32'd1);
      end
   endtask

   initial begin
      logic [9:0] seq1;

      reset     = 1'b1;
      tx_valid  = 1'b0;
      tx_data   = 8'h00;
      tx_valid1 = 1'b0;
      tx_data1  = 8'h00;

      // 1: reset and idle stability
      tick(); tick();
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         check("idle_out", 32'(tx_out), 32'd1);
         check("idle_ready", 32'(tx_ready), 32'd1);
         check("idle_busy", 32'(busy), 32'd0);
         check("idle_out1", 32'(tx_out1), 32'd1);
         tick();
      end

      // 2: single 0xA5 frame from a one-cycle valid pulse
      tx_data = 8'hA5; tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      expect_frame(8'hA5, "a5", 40, -1, 8'h00);
      tick();
      check("a5_stays_idle", 32'(tx_out), 32'd1);

      // 3: back-to-back with valid held: 0x00 then 0xFF, one idle cycle between
      tx_data = 8'h00; tx_valid = 1'b1;
      tick();
      tx_data = 8'hFF;
      expect_frame(8'h00, "b2b0", 40, -1, 8'h00);
      tick();
      tx_valid = 1'b0;
      expect_frame(8'hFF, "b2bf", 40, -1, 8'h00);

      // 4: tx_data change during DATA bit 2 does not affect the line
      tick();
      tx_data = 8'h3C; tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      expect_frame(8'h3C, "hold3c", 40, 13, 8'hC3);

      // 5: reset during DATA bit 3 of 0x5A, with tx_valid asserted under reset
      tick();
      tx_data = 8'h5A; tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      expect_frame(8'h5A, "rst5a", 18, -1, 8'h00);
      reset = 1'b1; tx_valid = 1'b1; tx_data = 8'h81;
      tick();
      check("rst_out", 32'(tx_out), 32'd1);
      check("rst_ready", 32'(tx_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      tick();
      check("rst_valid_ignored", 32'(busy), 32'd0);
      tx_valid = 1'b0;
      reset = 1'b0;
      tick();
      check("post_rst_idle", 32'(tx_out), 32'd1);
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      expect_frame(8'h81, "after81", 40, -1, 8'h00);

      // 6: CLKS_PER_BIT=1, 0x01 -> 0,1,0,0,0,0,0,0,0,1
      seq1 = 10'b10_0000_0010;
      tx_data1 = 8'h01; tx_valid1 = 1'b1;
      tick();
      tx_valid1 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check($sformatf("cpb1_c%0d", i), 32'(tx_out1), 32'(seq1[i]));
         check($sformatf("cpb1_busy_c%0d", i), 32'(busy1), 32'd1);
         tick();
      end
      check("cpb1_ready_back", 32'(tx_ready1), 32'd1);
      check("cpb1_idle_hi", 32'(tx_out1), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
